// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Purpose  : Shared constants for the 3x3 convolution datapath: command flag
//            bit positions, data/address widths, kernel taps and bias.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

  // One-hot command flag layout
  localparam int CMD_FLAG_W = 6;
  localparam int CMD_SET    = 0;
  localparam int CMD_READ   = 1;
  localparam int CMD_MULT   = 2;
  localparam int CMD_ROUND  = 3;
  localparam int CMD_ADD    = 4;
  localparam int CMD_WRITE  = 5;

  // Widths
  localparam int DATA_W  = 20;   // signed 4.16 pixel / coefficient
  localparam int PROD_W  = 40;   // signed 8.32 product
  localparam int ACC_W   = 44;   // signed accumulator
  localparam int ADDR_W  = 12;   // {row[5:0], col[5:0]}
  localparam int COORD_W = 6;
  localparam int CNT_W   = 4;

  // 3x3 kernel in raster order (signed 4.16)
  localparam logic [DATA_W-1:0] K [0:8] = '{
    20'h00001, 20'h02000, 20'hFF000,
    20'h04000, 20'h10000, 20'h04000,
    20'hFE000, 20'h02000, 20'h00800
  };

  // Bias added after rounding (signed 4.16)
  localparam logic [DATA_W-1:0] BIAS = 20'h01000;

endpackage
`default_nettype wire

// File: rtl/conv_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : conv_addr_gen
// Purpose  : Maps a tap index (0..8, raster order) around a centre pixel to
//            an image address and flags taps that fall outside the 64x64
//            image (zero padding).
// Ports    : crow, ccol - centre coordinates
//            idx        - tap index; values above 8 report invalid
//            addr       - {row, col} of the tap (meaningful when valid)
//            valid      - tap lies inside the image
// Revision : 1.0 - initial release
// ============================================================================
module conv_addr_gen
  import conv_pkg::*;
(
  input  logic [COORD_W-1:0] crow,
  input  logic [COORD_W-1:0] ccol,
  input  logic [CNT_W-1:0]   idx,
  output logic [ADDR_W-1:0]  addr,
  output logic               valid
);

  localparam logic [COORD_W-1:0] c_edge_max = '1;

  logic [1:0]         w_dr;
  logic [1:0]         w_dc;
  logic               w_idx_ok;
  logic [COORD_W-1:0] w_row;
  logic [COORD_W-1:0] w_col;
  logic               w_row_ok;
  logic               w_col_ok;

  // Offsets are stored +1 (0..2) so the arithmetic stays unsigned
  always_comb begin
    w_dr     = 2'd0;
    w_dc     = 2'd0;
    w_idx_ok = 1'b1;
    case (idx)
      4'd0:    begin w_dr = 2'd0; w_dc = 2'd0; end
      4'd1:    begin w_dr = 2'd0; w_dc = 2'd1; end
      4'd2:    begin w_dr = 2'd0; w_dc = 2'd2; end
      4'd3:    begin w_dr = 2'd1; w_dc = 2'd0; end
      4'd4:    begin w_dr = 2'd1; w_dc = 2'd1; end
      4'd5:    begin w_dr = 2'd1; w_dc = 2'd2; end
      4'd6:    begin w_dr = 2'd2; w_dc = 2'd0; end
      4'd7:    begin w_dr = 2'd2; w_dc = 2'd1; end
      4'd8:    begin w_dr = 2'd2; w_dc = 2'd2; end
      default: w_idx_ok = 1'b0;
    endcase
  end

  // Wraps harmlessly at the border; the valid flag masks those cases
  assign w_row = crow + {{(COORD_W-2){1'b0}}, w_dr} - COORD_W'(1);
  assign w_col = ccol + {{(COORD_W-2){1'b0}}, w_dc} - COORD_W'(1);

  assign w_row_ok = !((crow == '0 && w_dr == 2'd0) || (crow == c_edge_max && w_dr == 2'd2));
  assign w_col_ok = !((ccol == '0 && w_dc == 2'd0) || (ccol == c_edge_max && w_dc == 2'd2));

  assign addr  = {w_row, w_col};
  assign valid = w_idx_ok && w_row_ok && w_col_ok;

endmodule
`default_nettype wire

// File: rtl/conv_dp.sv
`default_nettype none
// ============================================================================
// Module   : conv_dp
// Purpose  : Command-driven 3x3 convolution datapath. An external controller
//            issues one-hot commands (SET, READ, MULT, ROUND, ADD, WRITE) and
//            clears the step counter between them with dp_cnt_rst.
// Ports    : clk, reset (sync, active-high)
//            cmd_flags, dp_cnt_rst        - command and step-counter clear
//            *_done, write_*_done         - combinational completion flags
//            iaddr / idata                - image read port (1-cycle latency)
//            cwr, caddr_wr, cdata_wr, csel - layer-memory write port
// Config   : CONV_RELU_EN - when defined, ADD clamps negative results to 0
// Revision : 1.0 - initial release
// ============================================================================
module conv_dp
  import conv_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CMD_FLAG_W-1:0] cmd_flags,
  input  logic                  dp_cnt_rst,
  output logic                  set_done,
  output logic                  read_done,
  output logic                  mult_done,
  output logic                  round_done,
  output logic                  add_done,
  output logic                  write_nyet_done,
  output logic                  write_all_done,
  output logic [ADDR_W-1:0]     iaddr,
  input  logic [DATA_W-1:0]     idata,
  output logic                  cwr,
  output logic [ADDR_W-1:0]     caddr_wr,
  output logic [DATA_W-1:0]     cdata_wr,
  output logic [2:0]            csel
);

  localparam logic [CNT_W-1:0]   c_cnt_max   = '1;
  localparam logic [CNT_W-1:0]   c_last_tap  = 4'd8;
  localparam logic [CNT_W-1:0]   c_read_end  = 4'd9;
  localparam logic [COORD_W-1:0] c_coord_max = '1;
  localparam logic [2:0]         c_csel_l0   = 3'b001;

  logic [CNT_W-1:0]          r_cnt;
  logic [COORD_W-1:0]        r_prow, r_pcol;   // output position
  logic [COORD_W-1:0]        r_crow, r_ccol;   // centre latched by SET
  logic [ACC_W-1:0]          r_acc;
  logic [DATA_W-1:0]         r_res;
  logic [8:0][DATA_W-1:0]    r_tap;
  logic [ADDR_W-1:0]         r_iaddr;
  logic                      r_pad_prev;       // tap requested last cycle was padding

  logic                      w_one_hot, w_go, w_first;
  logic                      w_set, w_read, w_mult, w_round, w_add, w_write;
  logic                      w_wr_fire, w_pos_last;
  logic [CNT_W-1:0]          w_tap_idx, w_cap_idx;
  logic [ADDR_W-1:0]         w_tap_addr, w_iaddr;
  logic                      w_tap_valid;
  logic [DATA_W-1:0]         w_tap, w_coef, w_sum, w_res_add;
  logic signed [PROD_W-1:0]  w_prod;
  logic [DATA_W-1:0]         w_rounded;

  // Illegal (zero or multi-hot) commands and a pending counter clear both
  // freeze the datapath; reset also blocks any command side effect.
  assign w_one_hot = (cmd_flags != '0) &&
                     ((cmd_flags & (cmd_flags - CMD_FLAG_W'(1))) == '0);
  assign w_go      = w_one_hot && !dp_cnt_rst && !reset;
  assign w_first   = (r_cnt == '0);

  assign w_set   = w_go && cmd_flags[CMD_SET];
  assign w_read  = w_go && cmd_flags[CMD_READ];
  assign w_mult  = w_go && cmd_flags[CMD_MULT];
  assign w_round = w_go && cmd_flags[CMD_ROUND];
  assign w_add   = w_go && cmd_flags[CMD_ADD];
  assign w_write = w_go && cmd_flags[CMD_WRITE];

  conv_addr_gen u_addr_gen (
    .crow  (r_crow),
    .ccol  (r_ccol),
    .idx   (r_cnt),
    .addr  (w_tap_addr),
    .valid (w_tap_valid)
  );

  // Padding taps leave the address bus where it was
  assign w_iaddr = (w_read && r_cnt <= c_last_tap && w_tap_valid) ? w_tap_addr : r_iaddr;
  assign iaddr   = w_iaddr;

  assign w_tap_idx = (r_cnt <= c_last_tap) ? r_cnt : '0;
  assign w_cap_idx = r_cnt - CNT_W'(1);
  assign w_tap     = r_tap[w_tap_idx];
  assign w_coef    = K[w_tap_idx];
  assign w_prod    = $signed({{(PROD_W-DATA_W){w_tap[DATA_W-1]}},  w_tap}) *
                     $signed({{(PROD_W-DATA_W){w_coef[DATA_W-1]}}, w_coef});

  // (acc + 2^15) >> 16, keeping 20 bits: the carry into bit 16 is acc[15]
  assign w_rounded = r_acc[DATA_W+15:16] + {{(DATA_W-1){1'b0}}, r_acc[15]};

  assign w_sum = r_res + BIAS;
`ifdef CONV_RELU_EN
  assign w_res_add = w_sum[DATA_W-1] ? '0 : w_sum;
`else
  assign w_res_add = w_sum;
`endif

  assign w_pos_last = (r_prow == c_coord_max) && (r_pcol == c_coord_max);
  assign w_wr_fire  = w_write && w_first;

  assign set_done        = w_set   && w_first;
  assign read_done       = w_read  && (r_cnt == c_read_end);
  assign mult_done       = w_mult  && (r_cnt == c_last_tap);
  assign round_done      = w_round && w_first;
  assign add_done        = w_add   && w_first;
  assign write_all_done  = w_wr_fire &&  w_pos_last;
  assign write_nyet_done = w_wr_fire && !w_pos_last;

  assign cwr      = w_wr_fire;
  assign caddr_wr = w_wr_fire ? {r_prow, r_pcol} : '0;
  assign cdata_wr = w_wr_fire ? r_res : '0;
  assign csel     = w_wr_fire ? c_csel_l0 : 3'b000;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_prow     <= '0;
      r_pcol     <= '0;
      r_crow     <= '0;
      r_ccol     <= '0;
      r_acc      <= '0;
      r_res      <= '0;
      r_tap      <= '0;
      r_iaddr    <= '0;
      r_pad_prev <= 1'b0;
    end else begin
      if (dp_cnt_rst) begin
        r_cnt <= '0;
      end else if (w_go && r_cnt != c_cnt_max) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      r_iaddr <= w_iaddr;

      if (w_set && w_first) begin
        r_crow <= r_prow;
        r_ccol <= r_pcol;
        r_acc  <= '0;
      end

      // idata answers the address issued one step earlier
      if (w_read) begin
        if (r_cnt <= c_last_tap) begin
          r_pad_prev <= !w_tap_valid;
        end
        if (r_cnt != '0 && r_cnt <= c_read_end) begin
          r_tap[w_cap_idx] <= r_pad_prev ? '0 : idata;
        end
      end

      if (w_mult && r_cnt <= c_last_tap) begin
        r_acc <= r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
      end

      if (w_round && w_first) begin
        r_res <= w_rounded;
      end

      if (w_add && w_first) begin
        r_res <= w_res_add;
      end

      if (w_wr_fire) begin
        if (r_pcol == c_coord_max) begin
          r_pcol <= '0;
          r_prow <= r_prow + COORD_W'(1);
        end else begin
          r_pcol <= r_pcol + COORD_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_dp.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_dp
// Purpose  : Self-checking bench for conv_dp. A 64x64 image memory answers
//            iaddr with one cycle of latency; a behavioural convolution model
//            predicts every layer-memory write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_dp;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  cmd_flags = '0;
  logic        dp_cnt_rst = 1'b0;
  logic        set_done, read_done, mult_done, round_done, add_done;
  logic        write_nyet_done, write_all_done;
  logic [11:0] iaddr;
  logic [19:0] idata;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic [2:0]  csel;

  always #5 clk = ~clk;

  conv_dp dut (
    .clk(clk), .reset(reset), .cmd_flags(cmd_flags), .dp_cnt_rst(dp_cnt_rst),
    .set_done(set_done), .read_done(read_done), .mult_done(mult_done),
    .round_done(round_done), .add_done(add_done),
    .write_nyet_done(write_nyet_done), .write_all_done(write_all_done),
    .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .csel(csel)
  );

  logic [19:0] img [4096];
  always @(posedge clk) idata <= img[iaddr];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          done_at;   // first cycle the command's own done was high
    int          done_hi;   // cycles with any done output high
    int          cwr_n;
    logic [11:0] caddr;
    logic [19:0] cdata;
    logic [2:0]  csel;
    logic        all_d;
    logic        nyet;
  } obs_t;

  int   iaddr_q[$];
  int   g_dat[6];
  int   g_dhi[6];
  obs_t g_wo;
  logic [19:0] m_res;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  function automatic logic [19:0] model_round(input int r, input int c);
    longint acc = 0;
    for (int k = 0; k < 9; k++) begin
      int tr = r + k / 3 - 1;
      int tc = c + k % 3 - 1;
      longint t = 0;
      if (tr >= 0 && tr < 64 && tc >= 0 && tc < 64)
        t = longint'($signed(img[tr * 64 + tc]));
      acc += t * longint'($signed(K[k]));
    end
    acc = acc + 32768;
    return 20'(acc >>> 16);
  endfunction

  function automatic logic [19:0] model_add(input logic [19:0] v);
    logic [19:0] s = v + BIAS;
`ifdef CONV_RELU_EN
    if (s[19]) s = '0;
`endif
    return s;
  endfunction

  // ---------------- drivers ----------------
  task automatic apply_reset();
    reset = 1'b1; cmd_flags = '0; dp_cnt_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_cmd(input int b, input int n, output obs_t o);
    logic [5:0] dn;
    o.done_at = -1; o.done_hi = 0; o.cwr_n = 0; o.caddr = '0; o.cdata = '0;
    o.csel = '0; o.all_d = 1'b0; o.nyet = 1'b0;
    cmd_flags = '0; dp_cnt_rst = 1'b1;
    @(posedge clk); #1;
    dp_cnt_rst = 1'b0; cmd_flags = 6'(1 << b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dn = {write_all_done | write_nyet_done, add_done, round_done,
            mult_done, read_done, set_done};
      if (dn != '0) o.done_hi++;
      if (dn[b] && o.done_at < 0) o.done_at = i;
      if (b == CMD_READ) iaddr_q.push_back(int'(iaddr));
      if (cwr) begin
        o.cwr_n++; o.caddr = caddr_wr; o.cdata = cdata_wr; o.csel = csel;
        o.all_d = write_all_done; o.nyet = write_nyet_done;
      end
      @(posedge clk); #1;
    end
    cmd_flags = '0;
  endtask

  task automatic do_pixel(input bit full, input bit add, input int rd_n,
                          input int mu_n, input int wr_n);
    obs_t o;
    for (int i = 0; i < 6; i++) begin g_dat[i] = -2; g_dhi[i] = 0; end
    if (full) begin
      run_cmd(CMD_SET, 1, o);      g_dat[0] = o.done_at; g_dhi[0] = o.done_hi;
      run_cmd(CMD_READ, rd_n, o);  g_dat[1] = o.done_at; g_dhi[1] = o.done_hi;
      run_cmd(CMD_MULT, mu_n, o);  g_dat[2] = o.done_at; g_dhi[2] = o.done_hi;
      run_cmd(CMD_ROUND, 1, o);    g_dat[3] = o.done_at; g_dhi[3] = o.done_hi;
      if (add) begin
        run_cmd(CMD_ADD, 1, o);    g_dat[4] = o.done_at; g_dhi[4] = o.done_hi;
      end
    end
    run_cmd(CMD_WRITE, wr_n, o);   g_dat[5] = o.done_at; g_dhi[5] = o.done_hi;
    g_wo = o;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 4096; i++) img[i] = '0;
    apply_reset();
    @(negedge clk);
    n_tests++;
    if ({iaddr, cwr, caddr_wr, cdata_wr, csel} !== '0 ||
        {set_done, read_done, mult_done, round_done, add_done,
         write_nyet_done, write_all_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: iaddr=%0h cwr=%0b caddr=%0h cdata=%0h csel=%0h expected all 0",
               iaddr, cwr, caddr_wr, cdata_wr, csel);
    end
    @(posedge clk); #1;
    do_pixel(1'b0, 1'b0, 0, 0, 1);
    n_tests++;
    if (g_wo.cwr_n !== 1 || g_wo.caddr !== 12'd0 || g_wo.cdata !== 20'd0 ||
        g_wo.nyet !== 1'b1 || g_wo.all_d !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state_write: cwr_n=%0d addr=%0h data=%0h nyet=%0b all=%0b expected 1/0/0/1/0",
               g_wo.cwr_n, g_wo.caddr, g_wo.cdata, g_wo.nyet, g_wo.all_d);
    end
  endtask

  task automatic test_padding();
    bit seen[4];
    for (int i = 0; i < 4096; i++) img[i] = 20'($urandom);
    apply_reset();
    iaddr_q.delete();
    m_res = model_add(model_round(0, 0));
    // hold READ, MULT and WRITE past their done cycles
    do_pixel(1'b1, 1'b1, 12, 12, 3);
    seen = '{default: 1'b0};
    foreach (iaddr_q[i]) begin
      n_tests++;
      case (iaddr_q[i])
        0:  seen[0] = 1'b1;
        1:  seen[1] = 1'b1;
        64: seen[2] = 1'b1;
        65: seen[3] = 1'b1;
        default: begin
          n_fail++;
          $display("FAIL pad_iaddr: got %0d expected one of 0,1,64,65", iaddr_q[i]);
        end
      endcase
    end
    n_tests++;
    if (seen[1] !== 1'b1 || seen[2] !== 1'b1 || seen[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL pad_visits: seen1=%0b seen64=%0b seen65=%0b expected 111", seen[1], seen[2], seen[3]);
    end
    n_tests++;
    if (g_wo.cwr_n !== 1 || g_wo.cdata !== m_res || g_wo.caddr !== 12'd0) begin
      n_fail++;
      $display("FAIL pad_result: cwr_n=%0d data=%0h addr=%0h expected 1/%0h/0",
               g_wo.cwr_n, g_wo.cdata, g_wo.caddr, m_res);
    end
    n_tests++;
    if (g_dat[1] !== 9 || g_dat[2] !== 8 || g_dhi[1] !== 1 || g_dhi[2] !== 1 || g_dhi[5] !== 1) begin
      n_fail++;
      $display("FAIL pad_done_timing: read_at=%0d mult_at=%0d read_hi=%0d mult_hi=%0d wr_hi=%0d expected 9/8/1/1/1",
               g_dat[1], g_dat[2], g_dhi[1], g_dhi[2], g_dhi[5]);
    end
  endtask

  task automatic test_illegal();
    int rd_at;
    // position is now (0,1); last real image address issued was 65
    cmd_flags = '0; dp_cnt_rst = 1'b1;
    @(posedge clk); #1;
    dp_cnt_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_flags = (i < 3) ? 6'b000110 : 6'b100001;
      @(negedge clk);
      n_tests++;
      if ({set_done, read_done, mult_done, round_done, add_done,
           write_nyet_done, write_all_done} !== '0 || cwr !== 1'b0 || iaddr !== 12'd65) begin
        n_fail++;
        $display("FAIL illegal_cmd: cmd=%b cwr=%0b iaddr=%0d expected no done, cwr 0, iaddr 65",
                 cmd_flags, cwr, iaddr);
      end
      @(posedge clk); #1;
    end
    for (int pass = 0; pass < 2; pass++) begin
      // pass 0: counter must still be 0 after the illegal cycles
      // pass 1: counter must be 0 after a clear that coincided with READ
      if (pass == 1) begin
        cmd_flags = 6'(1 << CMD_READ); dp_cnt_rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({set_done, read_done, mult_done, round_done, add_done,
             write_nyet_done, write_all_done} !== '0 || iaddr !== 12'd65) begin
          n_fail++;
          $display("FAIL clr_with_read: read_done=%0b iaddr=%0d expected 0/65", read_done, iaddr);
        end
        @(posedge clk); #1;
        dp_cnt_rst = 1'b0;
      end
      cmd_flags = 6'(1 << CMD_READ);
      rd_at = -1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (read_done && rd_at < 0) rd_at = i;
        @(posedge clk); #1;
      end
      n_tests++;
      if (rd_at !== 9) begin
        n_fail++;
        $display("FAIL illegal_cnt_hold pass%0d: read_done at %0d expected 9", pass, rd_at);
      end
    end
    cmd_flags = '0;
    m_res = model_add(model_round(0, 1));
    do_pixel(1'b1, 1'b1, 10, 9, 1);
    n_tests++;
    if (g_wo.caddr !== 12'd1 || g_wo.cdata !== m_res) begin
      n_fail++;
      $display("FAIL illegal_state_kept: addr=%0h data=%0h expected 1/%0h", g_wo.caddr, g_wo.cdata, m_res);
    end
  endtask

  task automatic test_round();
    for (int i = 0; i < 4096; i++) img[i] = '0;
    apply_reset();
    for (int p = 0; p < 65; p++) begin
      do_pixel(1'b0, 1'b0, 0, 0, 1);
      n_tests++;
      if (g_wo.caddr !== 12'(p) || g_wo.cdata !== 20'd0) begin
        n_fail++;
        $display("FAIL advance_write: addr=%0h data=%0h expected %0h/0", g_wo.caddr, g_wo.cdata, p);
      end
    end
    // pixel (1,1): tap 0 is (0,0); K[0] is one LSB, so acc equals the pixel value
    img[0] = 20'h08000;
    do_pixel(1'b1, 1'b0, 10, 9, 1);
    n_tests++;
    if (g_wo.cdata !== 20'd1 || g_dat[3] !== 0) begin
      n_fail++;
      $display("FAIL round_half_up: data=%0h round_at=%0d expected 1/0", g_wo.cdata, g_dat[3]);
    end
    img[0] = '0;
    img[1] = 20'h07FFF;
    do_pixel(1'b1, 1'b0, 10, 9, 1);
    n_tests++;
    if (g_wo.cdata !== 20'd0 || g_wo.caddr !== 12'd66) begin
      n_fail++;
      $display("FAIL round_below_half: data=%0h addr=%0h expected 0/42", g_wo.cdata, g_wo.caddr);
    end
    img[1] = '0;
  endtask

  task automatic test_relu();
    logic [19:0] exp_v;
    // pixel (1,3): centre tap weighted 1.0, so ROUND returns it and ADD adds BIAS
    img[67] = 20'h F0000 - BIAS;
`ifdef CONV_RELU_EN
    exp_v = 20'h00000;
`else
    exp_v = 20'hF0000;
`endif
    do_pixel(1'b1, 1'b1, 10, 9, 1);
    n_tests++;
    if (g_wo.cdata !== exp_v || g_wo.caddr !== 12'd67 || g_dat[4] !== 0) begin
      n_fail++;
      $display("FAIL relu_minus_one: data=%0h addr=%0h add_at=%0d expected %0h/43/0",
               g_wo.cdata, g_wo.caddr, g_dat[4], exp_v);
    end
    img[67] = '0;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    for (int i = 0; i < 4096; i++) img[i] = 20'($urandom);
    run_cmd(CMD_SET, 1, o);
    run_cmd(CMD_READ, 10, o);
    cmd_flags = '0; dp_cnt_rst = 1'b1;
    @(posedge clk); #1;
    dp_cnt_rst = 1'b0; cmd_flags = 6'(1 << CMD_MULT);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cwr !== 1'b0 || mult_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_mult: cwr=%0b mult_done=%0b expected 0/0", cwr, mult_done);
    end
    @(posedge clk); #1;
    reset = 1'b0; cmd_flags = '0;
    @(negedge clk);
    n_tests++;
    if ({iaddr, cwr, caddr_wr, cdata_wr, csel} !== '0 ||
        {set_done, read_done, mult_done, round_done, add_done,
         write_nyet_done, write_all_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: iaddr=%0h cwr=%0b caddr=%0h cdata=%0h csel=%0h expected all 0",
               iaddr, cwr, caddr_wr, cdata_wr, csel);
    end
    @(posedge clk); #1;
    reset = 1'b1; cmd_flags = 6'(1 << CMD_WRITE);
    @(negedge clk);
    n_tests++;
    if (cwr !== 1'b0 || write_nyet_done !== 1'b0 || write_all_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_blocks_write: cwr=%0b nyet=%0b all=%0b expected 0/0/0",
               cwr, write_nyet_done, write_all_done);
    end
    @(posedge clk); #1;
    reset = 1'b0; cmd_flags = '0;
    m_res = model_add(model_round(0, 0));
    do_pixel(1'b1, 1'b1, 10, 9, 1);
    n_tests++;
    if (g_wo.caddr !== 12'd0 || g_wo.cdata !== m_res) begin
      n_fail++;
      $display("FAIL reset_mid_restart: addr=%0h data=%0h expected 0/%0h", g_wo.caddr, g_wo.cdata, m_res);
    end
  endtask

  task automatic test_full_sequence();
    int  r, c;
    bit  full;
    int  all_cnt = 0;
    for (int i = 0; i < 4096; i++) img[i] = 20'($urandom);
    apply_reset();
    m_res = '0;
    for (int p = 0; p < 4096; p++) begin
      r = p / 64; c = p % 64;
      full = (r == 0 || r == 63 || c == 0 || c == 63 || $urandom_range(0, 31) == 0);
      if (full) m_res = model_add(model_round(r, c));
      do_pixel(full, 1'b1, 10, 9, 1);
      if (g_wo.all_d) all_cnt++;
      n_tests++;
      if (g_wo.cwr_n !== 1 || g_wo.caddr !== 12'(p) || g_wo.cdata !== m_res || g_wo.csel !== 3'b001 ||
          g_wo.all_d !== (p == 4095) || g_wo.nyet !== (p != 4095)) begin
        n_fail++;
        $display("FAIL seq_write p=%0d: cwr_n=%0d addr=%0h data=%0h csel=%0h all=%0b nyet=%0b expected 1/%0h/%0h/1/%0b/%0b",
                 p, g_wo.cwr_n, g_wo.caddr, g_wo.cdata, g_wo.csel, g_wo.all_d, g_wo.nyet,
                 p, m_res, p == 4095, p != 4095);
      end
      if (full) begin
        n_tests++;
        if (g_dat[0] !== 0 || g_dat[1] !== 9 || g_dat[2] !== 8 || g_dat[3] !== 0 || g_dat[4] !== 0) begin
          n_fail++;
          $display("FAIL seq_done p=%0d: set=%0d read=%0d mult=%0d round=%0d add=%0d expected 0/9/8/0/0",
                   p, g_dat[0], g_dat[1], g_dat[2], g_dat[3], g_dat[4]);
        end
      end
    end
    n_tests++;
    if (all_cnt !== 1) begin
      n_fail++;
      $display("FAIL seq_all_done_count: got %0d expected 1", all_cnt);
    end
    // position wraps back to (0,0)
    do_pixel(1'b0, 1'b0, 0, 0, 1);
    n_tests++;
    if (g_wo.caddr !== 12'd0 || g_wo.nyet !== 1'b1) begin
      n_fail++;
      $display("FAIL seq_wrap: addr=%0h nyet=%0b expected 0/1", g_wo.caddr, g_wo.nyet);
    end
  endtask

  initial begin
    test_reset();
    test_padding();
    test_illegal();
    test_round();
    test_relu();
    test_reset_mid();
    test_full_sequence();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
